// File: rtl/flag_unit.sv
// flag_unit
//   Holds the architectural N/V/Z condition flags and updates them from the
//   EX-stage ALU result when a flag-writing instruction commits. Counts
//   flag writers that have left ID but not yet committed, and gives the
//   ID-stage branch logic a ready/stall handshake. The flags it hands to
//   the branch are forwarded combinationally from EX.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   id_issue   in   instruction leaves ID this cycle
//   id_opcode  in   opcode of the issuing instruction
//   flush      in   squash: in-flight count cleared, id_issue ignored
//   ex_valid   in   EX holds a valid instruction committing this cycle
//   ex_opcode  in   opcode in EX
//   ex_result  in   ALU result in EX
//   ex_ovfl    in   ALU signed overflow in EX
//   br_req     in   conditional branch in ID needs flags this cycle
//   F          out  flags {N,V,Z}, forwarded from EX on a commit
//   br_ready   out  F is valid for a branch this cycle
//   br_stall   out  br_req & ~br_ready
//   pend       out  in-flight flag-writer count
//   err        out  sticky protocol error (underflow or overflow of pend)
module flag_unit #(
    parameter int MAX_PEND = 2,
    localparam int PW = $clog2(MAX_PEND + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_issue,
    input  logic [3:0]    id_opcode,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [15:0]   ex_result,
    input  logic          ex_ovfl,
    input  logic          br_req,
    output logic [2:0]    F,
    output logic          br_ready,
    output logic          br_stall,
    output logic [PW-1:0] pend,
    output logic          err
);

    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
    localparam logic [PW-1:0] PEND_ONE = PW'(1);

    logic [2:0]    flags_q;
    logic [2:0]    flags_next;
    logic [PW-1:0] pend_q;
    logic [PW-1:0] pend_next;
    logic          err_q;
    logic          err_set;

    logic ex_nvz;
    logic ex_zonly;
    logic id_writer;
    logic commit;
    logic issue;

    // ADD/SUB write all three flags; the logical/shift group writes Z only.
    function automatic logic op_nvz(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001);
    endfunction

    function automatic logic op_zonly(input logic [3:0] op);
        return (op == 4'b0010) || (op == 4'b0100) ||
               (op == 4'b0101) || (op == 4'b0110);
    endfunction

    always_comb begin
        ex_nvz    = op_nvz(ex_opcode);
        ex_zonly  = op_zonly(ex_opcode);
        id_writer = op_nvz(id_opcode) || op_zonly(id_opcode);
        commit    = ex_valid && (ex_nvz || ex_zonly);
        issue     = id_issue && !flush && id_writer;
    end

    always_comb begin
        flags_next = flags_q;
        if (commit) begin
            flags_next[0] = (ex_result == 16'h0000);
            if (ex_nvz) begin
                flags_next[2] = ex_result[15];
                flags_next[1] = ex_ovfl;
            end
        end
    end

    // A flush in the same cycle as a commit hides the underflow: the commit
    // belongs to an instruction older than the squash point.
    always_comb begin
        pend_next = pend_q;
        err_set   = 1'b0;
        if (commit && (pend_q == '0) && !flush) begin
            err_set = 1'b1;
        end
        if (issue && (pend_q == PEND_MAX) && !commit) begin
            err_set = 1'b1;
        end
        if (flush) begin
            pend_next = '0;
        end else if (issue && !commit) begin
            if (pend_q != PEND_MAX) begin
                pend_next = pend_q + PEND_ONE;
            end
        end else if (commit && !issue) begin
            if (pend_q != '0) begin
                pend_next = pend_q - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_next;
            pend_q  <= pend_next;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Only the oldest in-flight writer can be forwarded, so a commit makes
    // the flags usable only when it is the last one outstanding.
    always_comb begin
        F        = flags_next;
        br_ready = (pend_q == '0) || ((pend_q == PEND_ONE) && commit);
        br_stall = br_req && !br_ready;
        pend     = pend_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

    localparam int MAXP = 2;
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_PADDSB = 4'b1000;

    logic        clk;
    logic        rst_n;
    logic        id_issue;
    logic [3:0]  id_opcode;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovfl;
    logic        br_req;
    logic [2:0]  f;
    logic        br_ready;
    logic        br_stall;
    logic [1:0]  pend;
    logic        err;

    int total;
    int bad;

    // reference model state
    int         m_pend;
    logic [2:0] m_flags;
    logic       m_err;

    flag_unit #(.MAX_PEND(MAXP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_issue  (id_issue),
        .id_opcode (id_opcode),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_opcode (ex_opcode),
        .ex_result (ex_result),
        .ex_ovfl   (ex_ovfl),
        .br_req    (br_req),
        .F         (f),
        .br_ready  (br_ready),
        .br_stall  (br_stall),
        .pend      (pend),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // 0 = writes nothing, 1 = writes N,V,Z, 2 = writes Z only
    function automatic int op_class(input logic [3:0] op);
        case (op)
            4'd0, 4'd1:             return 1;
            4'd2, 4'd4, 4'd5, 4'd6: return 2;
            default:                return 0;
        endcase
    endfunction

    function automatic bit m_commit();
        return ex_valid && (op_class(ex_opcode) != 0);
    endfunction

    function automatic logic [2:0] m_fwd();
        logic [2:0] r;
        r = m_flags;
        if (m_commit()) begin
            r[0] = (ex_result == 16'h0000);
            if (op_class(ex_opcode) == 1) begin
                r[2] = ex_result[15];
                r[1] = ex_ovfl;
            end
        end
        return r;
    endfunction

    function automatic bit m_ready();
        return (m_pend == 0) || (m_pend == 1 && m_commit());
    endfunction

    task automatic model_reset();
        m_pend  = 0;
        m_flags = 3'b000;
        m_err   = 1'b0;
    endtask

    // Apply inputs and check the combinational outputs against the model.
    task automatic drive(input logic iss, input logic [3:0] iop, input logic fl,
                         input logic exv, input logic [3:0] eop, input logic [15:0] res,
                         input logic ov, input logic brq);
        id_issue  = iss;
        id_opcode = iop;
        flush     = fl;
        ex_valid  = exv;
        ex_opcode = eop;
        ex_result = res;
        ex_ovfl   = ov;
        br_req    = brq;
        #1;
        chk("F", 32'(f), 32'(m_fwd()));
        chk("br_ready", 32'(br_ready), 32'(m_ready()));
        chk("br_stall", 32'(br_stall), 32'(brq && !m_ready()));
    endtask

    // Advance the model across one clock edge and check the registers.
    task automatic tick();
        bit c;
        bit is;
        c  = m_commit();
        is = id_issue && !flush && (op_class(id_opcode) != 0);
        if (c && m_pend == 0 && !flush) m_err = 1'b1;
        if (is && m_pend == MAXP && !c) m_err = 1'b1;
        if (c) m_flags = m_fwd();
        if (flush) begin
            m_pend = 0;
        end else begin
            m_pend = m_pend + int'(is) - int'(c);
            if (m_pend < 0) m_pend = 0;
            if (m_pend > MAXP) m_pend = MAXP;
        end
        @(posedge clk);
        #1;
        chk("pend", 32'(pend), 32'(m_pend));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic idle();
        drive(0, 4'd0, 0, 0, 4'd0, 16'h0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        id_issue = 0; id_opcode = 0; flush = 0; ex_valid = 0;
        ex_opcode = 0; ex_result = 0; ex_ovfl = 0; br_req = 0;
        model_reset();
        #1;
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_F", 32'(f), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        do_reset();

        // idle after reset, branch asking
        drive(0, 4'd0, 0, 0, 4'd0, 16'h0, 0, 1);
        chk("idle_F", 32'(f), 32'd0);
        chk("idle_ready", 32'(br_ready), 32'd1);
        chk("idle_stall", 32'(br_stall), 32'd0);
        tick();

        // ADD then SUB commits
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(0, 4'd0, 0, 1, OP_ADD, 16'h8000, 1, 0);
        chk("add_F", 32'(f), 32'b110);
        tick();
        idle();
        chk("add_flags_q", 32'(f), 32'b110);
        tick();
        drive(1, OP_SUB, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(0, 4'd0, 0, 1, OP_SUB, 16'h0000, 0, 0);
        chk("sub_F", 32'(f), 32'b001);
        tick();

        // Z-only hold, non-writer ignored
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(0, 4'd0, 0, 1, OP_ADD, 16'h8000, 1, 0); tick();
        drive(1, OP_XOR, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(0, 4'd0, 0, 1, OP_XOR, 16'h0000, 0, 0);
        chk("xor_F", 32'(f), 32'b111);
        tick();
        drive(0, 4'd0, 0, 1, OP_PADDSB, 16'h0000, 0, 0);
        chk("paddsb_F", 32'(f), 32'b111);
        tick();
        chk("paddsb_pend", 32'(pend), 32'd0);
        chk("paddsb_err", 32'(err), 32'd0);

        // stall then forward
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(0, 4'd0, 0, 0, 4'd0, 16'h0, 0, 1);
        chk("stall", 32'(br_stall), 32'd1);
        tick();
        drive(0, 4'd0, 0, 1, OP_ADD, 16'h0001, 0, 1);
        chk("fwd_ready", 32'(br_ready), 32'd1);
        chk("fwd_F", 32'(f), 32'b000);
        tick();

        // two in flight
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(1, OP_SUB, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        chk("two_pend", 32'(pend), 32'd2);
        drive(0, 4'd0, 0, 1, OP_ADD, 16'h1234, 0, 1);
        chk("two_first_ready", 32'(br_ready), 32'd0);
        tick();
        drive(0, 4'd0, 0, 1, OP_SUB, 16'hF000, 1, 1);
        chk("two_second_ready", 32'(br_ready), 32'd1);
        chk("two_second_F", 32'(f), 32'b110);
        tick();
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(1, OP_ADD, 0, 1, OP_ADD, 16'h0000, 0, 0); tick();
        chk("issue_commit_pend", 32'(pend), 32'd1);
        drive(0, 4'd0, 0, 1, OP_ADD, 16'h0005, 0, 0); tick();

        // async reset mid-count
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        chk("pre_rst_pend", 32'(pend), 32'd2);
        do_reset();
        idle();
        tick();

        // underflow error
        drive(0, 4'd0, 0, 1, OP_ADD, 16'h0000, 0, 0); tick();
        chk("uflow_err", 32'(err), 32'd1);
        chk("uflow_pend", 32'(pend), 32'd0);
        idle(); tick();
        chk("uflow_sticky", 32'(err), 32'd1);

        // overflow error
        do_reset();
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        chk("oflow_err", 32'(err), 32'd1);
        chk("oflow_pend", 32'(pend), 32'd2);

        // flush at pend=2 with issue, and flush with commit
        do_reset();
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(1, OP_ADD, 0, 0, 4'd0, 16'h0, 0, 0); tick();
        drive(1, OP_ADD, 1, 0, 4'd0, 16'h0, 0, 0); tick();
        chk("flush_pend", 32'(pend), 32'd0);
        chk("flush_err", 32'(err), 32'd0);
        drive(0, 4'd0, 1, 1, OP_SUB, 16'h8001, 1, 0); tick();
        chk("flush_commit_err", 32'(err), 32'd0);
        idle();
        chk("flush_commit_F", 32'(f), 32'b110);
        tick();

        // randomized traffic, reset periodically so err does not saturate
        for (int r = 0; r < 25; r++) begin
            do_reset();
            for (int c = 0; c < 30; c++) begin
                logic [15:0] res;
                res = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                drive(logic'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15) < 8 ? $urandom_range(0, 6) : $urandom_range(7, 15)),
                      logic'($urandom_range(0, 9) == 0),
                      logic'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15) < 8 ? $urandom_range(0, 6) : $urandom_range(7, 15)),
                      res,
                      logic'($urandom_range(0, 1)),
                      logic'($urandom_range(0, 1)));
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
# flag_unit

Producer side of the NVZ condition flags that the branch PC-control logic consumes. The block holds the architectural N/V/Z register and updates it from the EX-stage ALU result according to opcode. It tracks flag-writing instructions that have issued from ID but not yet committed, and it gives ID-stage branches a ready/stall handshake with forwarded flags. It sits between the EX stage (write side) and the decode-stage branch logic (read side).

## Interface
- MAX_PEND, default 2: maximum in-flight flag writers between issue and commit; counter width is clog2(MAX_PEND+1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_issue  in  1  instruction leaves ID this cycle (not stalled).
- id_opcode  in  4  opcode of the issuing instruction.
- flush  in  1  squash: pending count cleared, id_issue ignored this cycle.
- ex_valid  in  1  EX holds a valid instruction committing this cycle.
- ex_opcode  in  4  opcode in EX.
- ex_result  in  16  ALU result in EX.
- ex_ovfl  in  1  ALU signed overflow in EX.
- br_req  in  1  conditional branch in ID needs flags this cycle.
- F  out  3  flags {N,V,Z}; F[2]=N, F[1]=V, F[0]=Z; forwarded value.
- br_ready  out  1  F is valid for the requesting branch.
- br_stall  out  1  br_req & ~br_ready.
- pend  out  clog2(MAX_PEND+1)  current in-flight writer count.
- err  out  1  sticky protocol error.

## Operation
- Flag-writer classes by opcode:
  - ADD 0000, SUB 0001 write N, V and Z.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110 write Z only.
  - All other opcodes write nothing.
- Commit condition: ex_valid & writer(ex_opcode).
- Next flag values on commit:
  - Z = (ex_result == 16'h0000).
  - N = ex_result[15].
  - V = ex_ovfl.
  - Z-only classes leave N and V holding.
- flags_q is registered. F = commit ? flags_next : flags_q, giving combinational forwarding from EX.
- Issue condition: id_issue & ~flush & writer(id_opcode).
- pend next value:
  - Issue only: pend+1.
  - Commit only: pend−1.
  - Issue and commit together: pend unchanged.
  - flush: 0. A commit in the same cycle still updates flags_q.
- br_ready = (pend==0) | (pend==1 & commit). Only the oldest writer can be forwarded. br_ready is valid regardless of br_req.
- err sets, and holds until reset, on either:
  - commit while pend==0 and no flush;
  - issue while pend==MAX_PEND and no commit.
  On error, pend saturates at 0 or MAX_PEND. There is no wrap-around.

## Timing
- Reset (async, rst_n low) values:
  - flags_q=3'b000, pend=0, err=0.
  - Outputs with idle inputs: F=000, br_ready=1, br_stall=0.
- F, br_ready and br_stall are combinational from the registers and the current-cycle ex_* inputs. Commit-to-branch latency is 0 cycles.
- flags_q, pend and err update on the rising clk edge.
- An issue in cycle t makes br_ready=0 from t+1 until the cycle that writer commits.
- Reset asserted mid-operation clears everything immediately. The first edge after release behaves as after a fresh reset.
- Simultaneous flush and commit: flags_q is updated and pend goes to 0. No err is raised for a commit with pend==0 in that cycle.

## Test plan
- Reset, then idle: after rst_n rises, F=000, br_ready=1, pend=0, err=0. Assert rst_n low mid-count (pend=2): pend goes to 0 asynchronously.
- ADD commit: ex_opcode=0000, ex_result=16'h8000, ex_ovfl=1 → F=110 in the same cycle, flags_q=110 next cycle. Then SUB with result 0, ovfl 0 → F=001.
- Z-only hold: flags_q=110, XOR commit with ex_result=0 → F=111. Then PADDSB commit with result 0 → F stays 111, pend unchanged.
- Stall/forward: issue ADD at t with pend 0→1. Branch at t+1 with no commit → br_stall=1. Commit at t+2 (result 16'h0001) → br_ready=1, F=000.
- Two in flight: two ADD issues (pend=2), then commit of the first → br_ready=0. Next cycle pend=1; commit of the second → br_ready=1. Simultaneous issue and commit at pend=1 → pend stays 1.
- Errors and flush:
  - Commit with pend=0 → err=1 sticky, pend stays 0.
  - Third issue at pend=2 → err, pend stays 2.
  - flush with an issue at pend=2 → pend=0, no err.
